// File: rtl/point_cloud_bram_responder_pkg.sv
// Shared constants and FSM encoding for the point-cloud BRAM responder.
// Defaults here seed the parameters of the top and the bank.
package point_cloud_bram_responder_pkg;

  localparam int PC_N          = 16;
  localparam int PC_BUS_SIZE   = 32;
  localparam int PC_BRAM_SHIFT = 2;
  localparam int PC_PPW        = PC_BUS_SIZE / PC_N;
  localparam int HEADER_WORDS  = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_HDR_SIZE = 3'd2,
    S_HDR_GO   = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/pc_bram_bank.sv
// One axis bank: single-port, byte-enable, read-first BRAM with a
// registered engine read port and a loader/engine write mux.
module pc_bram_bank
  import point_cloud_bram_responder_pkg::*;
#(
  parameter int BUS_SIZE = PC_BUS_SIZE,
  parameter int DEPTH    = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           eng_word,
  input  logic [BUS_SIZE-1:0]   eng_wdata,
  input  logic [BUS_SIZE/8-1:0] eng_we,
  input  logic                  eng_en,
  input  logic                  eng_rst,
  input  logic                  eng_wr_ok,
  input  logic [31:0]           ld_word,
  input  logic [BUS_SIZE-1:0]   ld_wdata,
  input  logic [BUS_SIZE/8-1:0] ld_we,
  output logic [BUS_SIZE-1:0]   read_out
);

  localparam int BE_W = BUS_SIZE / 8;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BUS_SIZE-1:0] mem [DEPTH];

  logic            eng_hit;
  logic            ld_hit;
  logic [AW-1:0]   eng_idx;
  logic [AW-1:0]   ld_idx;
  logic            wr_ld;
  logic            wr_eng;
  logic [AW-1:0]   wr_idx;
  logic [BUS_SIZE-1:0] wr_data;
  logic [BE_W-1:0] wr_be;

  assign eng_hit = eng_word < 32'(DEPTH);
  assign ld_hit  = ld_word < 32'(DEPTH);
  assign eng_idx = eng_word[AW-1:0];
  assign ld_idx  = ld_word[AW-1:0];

  assign wr_ld  = (|ld_we) && ld_hit;
  assign wr_eng = !wr_ld && eng_wr_ok && eng_en
                  && (|eng_we) && eng_hit;

  // Loader has priority; engine writes only reach here in RUN.
  always_comb begin
    wr_idx  = eng_idx;
    wr_data = eng_wdata;
    wr_be   = '0;
    unique case (1'b1)
      wr_ld: begin
        wr_idx  = ld_idx;
        wr_data = ld_wdata;
        wr_be   = ld_we;
      end
      wr_eng: wr_be = eng_we;
      default: ;
    endcase
  end

  // Byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  // Registered read: old word on a same-cycle write, 0 off the end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_out <= '0;
    end else if (eng_en) begin
      if (eng_rst || !eng_hit) read_out <= '0;
      else                     read_out <= mem[eng_idx];
    end
  end

endmodule

// File: rtl/point_cloud_bram_responder.sv
// Streams host points into x/y/z banks, writes the size/start header,
// then serves the engine until it signals completion through z word 0.
module point_cloud_bram_responder
  import point_cloud_bram_responder_pkg::*;
#(
  parameter int N          = PC_N,
  parameter int BUS_SIZE   = PC_BUS_SIZE,
  parameter int BRAM_SHIFT = PC_BRAM_SHIFT,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           addr_x,
  input  logic [31:0]           addr_y,
  input  logic [31:0]           addr_z,
  input  logic [BUS_SIZE-1:0]   write_in_x,
  input  logic [BUS_SIZE-1:0]   write_in_y,
  input  logic [BUS_SIZE-1:0]   write_in_z,
  input  logic [BUS_SIZE/8-1:0] we_x,
  input  logic [BUS_SIZE/8-1:0] we_y,
  input  logic [BUS_SIZE/8-1:0] we_z,
  input  logic                  en_x,
  input  logic                  en_y,
  input  logic                  en_z,
  input  logic                  rst_x,
  input  logic                  rst_y,
  input  logic                  rst_z,
  output logic [BUS_SIZE-1:0]   read_out_x,
  output logic [BUS_SIZE-1:0]   read_out_y,
  output logic [BUS_SIZE-1:0]   read_out_z,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [N-1:0]          s_x,
  input  logic [N-1:0]          s_y,
  input  logic [N-1:0]          s_z,
  input  logic                  s_last,
  output logic                  done,
  input  logic                  done_ack,
  output logic                  busy,
  output logic                  overflow
);

  localparam int PPW        = BUS_SIZE / N;
  localparam int BE_W       = BUS_SIZE / 8;
  localparam int LANE_BYTES = N / 8;
  localparam int MAX_POINTS = (DEPTH - HEADER_WORDS) * PPW;
  localparam logic [31:0] MAX_CNT = 32'(MAX_POINTS);
  localparam logic [BE_W-1:0] LANE_BE =
    BE_W'((1 << LANE_BYTES) - 1);

  state_t      state;
  logic [31:0] count;
  logic        accept;
  logic [31:0] k;
  logic [31:0] cnt_nxt;
  logic [31:0] lane;
  logic [31:0] pt_word;
  logic [BE_W-1:0] pt_be;
  logic [31:0] word_x;
  logic [31:0] word_y;
  logic [31:0] word_z;
  logic        z_hit;
  logic        eng_wr_ok;

  logic [31:0]         ld_word;
  logic [BUS_SIZE-1:0] ld_x;
  logic [BUS_SIZE-1:0] ld_y;
  logic [BUS_SIZE-1:0] ld_z;
  logic [BE_W-1:0]     ld_we_x;
  logic [BE_W-1:0]     ld_we_y;
  logic [BE_W-1:0]     ld_we_z;

  assign accept  = s_valid && s_ready
                   && (state == S_IDLE || state == S_LOAD);
  assign k       = (state == S_IDLE) ? 32'd0 : count;
  assign cnt_nxt = k + 32'd1;
  assign lane    = k % 32'(PPW);
  assign pt_word = 32'(HEADER_WORDS) + k / 32'(PPW);
  assign pt_be   = (s_last && lane == 32'd0) ? '1
                   : LANE_BE << (lane * 32'(LANE_BYTES));

  assign word_x    = addr_x >> BRAM_SHIFT;
  assign word_y    = addr_y >> BRAM_SHIFT;
  assign word_z    = addr_z >> BRAM_SHIFT;
  assign eng_wr_ok = (state == S_RUN);
  assign z_hit     = en_z && (|we_z) && (|write_in_z)
                     && word_z == 32'd0;

  // Loader port: stream points, then size header, then start flag.
  always_comb begin
    ld_word = '0;
    ld_x    = '0;
    ld_y    = '0;
    ld_z    = '0;
    ld_we_x = '0;
    ld_we_y = '0;
    ld_we_z = '0;
    unique case (1'b1)
      accept: begin
        ld_word = pt_word;
        ld_x    = BUS_SIZE'(s_x) << (lane * 32'(N));
        ld_y    = BUS_SIZE'(s_y) << (lane * 32'(N));
        ld_z    = BUS_SIZE'(s_z) << (lane * 32'(N));
        ld_we_x = pt_be;
        ld_we_y = pt_be;
        ld_we_z = pt_be;
      end
      (state == S_HDR_SIZE): begin
        ld_x    = BUS_SIZE'(count);
        ld_we_x = '1;
        ld_we_z = '1;
      end
      (state == S_HDR_GO): begin
        ld_y    = BUS_SIZE'(1);
        ld_we_y = '1;
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      count    <= '0;
      s_ready  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_LOAD: begin
          s_ready <= 1'b1;
          if (accept) begin
            count <= cnt_nxt;
            busy  <= 1'b1;
            if (s_last) begin
              state   <= S_HDR_SIZE;
              s_ready <= 1'b0;
            end else if (cnt_nxt >= MAX_CNT) begin
              state    <= S_HDR_SIZE;
              s_ready  <= 1'b0;
              overflow <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_HDR_SIZE: state <= S_HDR_GO;
        S_HDR_GO:   state <= S_RUN;
        S_RUN: begin
          if (z_hit) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          if (done_ack) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            overflow <= 1'b0;
            s_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  pc_bram_bank #(.BUS_SIZE(BUS_SIZE), .DEPTH(DEPTH)) u_bank_x (
    .clock(clock), .reset_n(reset_n),
    .eng_word(word_x), .eng_wdata(write_in_x), .eng_we(we_x),
    .eng_en(en_x), .eng_rst(rst_x), .eng_wr_ok(eng_wr_ok),
    .ld_word(ld_word), .ld_wdata(ld_x), .ld_we(ld_we_x),
    .read_out(read_out_x)
  );

  pc_bram_bank #(.BUS_SIZE(BUS_SIZE), .DEPTH(DEPTH)) u_bank_y (
    .clock(clock), .reset_n(reset_n),
    .eng_word(word_y), .eng_wdata(write_in_y), .eng_we(we_y),
    .eng_en(en_y), .eng_rst(rst_y), .eng_wr_ok(eng_wr_ok),
    .ld_word(ld_word), .ld_wdata(ld_y), .ld_we(ld_we_y),
    .read_out(read_out_y)
  );

  pc_bram_bank #(.BUS_SIZE(BUS_SIZE), .DEPTH(DEPTH)) u_bank_z (
    .clock(clock), .reset_n(reset_n),
    .eng_word(word_z), .eng_wdata(write_in_z), .eng_we(we_z),
    .eng_en(en_z), .eng_rst(rst_z), .eng_wr_ok(eng_wr_ok),
    .ld_word(ld_word), .ld_wdata(ld_z), .ld_we(ld_we_z),
    .read_out(read_out_z)
  );

endmodule

// File: tb/tb_point_cloud_bram_responder.sv
// Bench for point_cloud_bram_responder: default-depth DUT plus a
// DEPTH=4 copy on the same stimulus for the overflow case.
module tb_point_cloud_bram_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [31:0] addr_x, addr_y, addr_z;
  logic [31:0] write_in_x, write_in_y, write_in_z;
  logic [3:0]  we_x, we_y, we_z;
  logic        en_x, en_y, en_z;
  logic        rst_x, rst_y, rst_z;
  logic        s_valid, s_last, done_ack;
  logic [15:0] s_x, s_y, s_z;

  logic [31:0] ro_x, ro_y, ro_z;
  logic        s_ready, done, busy, overflow;
  logic [31:0] so_x, so_y, so_z;
  logic        s_ready4, done4, busy4, overflow4;

  point_cloud_bram_responder dut (
    .clock(clock), .reset_n(reset_n),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
    .write_in_x(write_in_x), .write_in_y(write_in_y),
    .write_in_z(write_in_z),
    .we_x(we_x), .we_y(we_y), .we_z(we_z),
    .en_x(en_x), .en_y(en_y), .en_z(en_z),
    .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z),
    .read_out_x(ro_x), .read_out_y(ro_y), .read_out_z(ro_z),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
    .done(done), .done_ack(done_ack),
    .busy(busy), .overflow(overflow)
  );

  point_cloud_bram_responder #(.DEPTH(4)) dut4 (
    .clock(clock), .reset_n(reset_n),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
    .write_in_x(write_in_x), .write_in_y(write_in_y),
    .write_in_z(write_in_z),
    .we_x(we_x), .we_y(we_y), .we_z(we_z),
    .en_x(en_x), .en_y(en_y), .en_z(en_z),
    .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z),
    .read_out_x(so_x), .read_out_y(so_y), .read_out_z(so_z),
    .s_valid(s_valid), .s_ready(s_ready4),
    .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
    .done(done4), .done_ack(done_ack),
    .busy(busy4), .overflow(overflow4)
  );

  typedef struct packed {
    int          dsel;
    int          bank;
    logic [31:0] exp;
  } rd_t;

  rd_t   rd_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ro(input int dsel, input int bank);
    logic [31:0] v;
    case (bank)
      0:       v = (dsel == 0) ? ro_x : so_x;
      1:       v = (dsel == 0) ? ro_y : so_y;
      default: v = (dsel == 0) ? ro_z : so_z;
    endcase
    return v;
  endfunction

  // Point k of the first stream: x=(k+1)*0x0101, y/z offset per bank.
  function automatic logic [15:0] pval(input int bank, input int k);
    return 16'((k + 1) * 16'h0101 + bank * 16'h1000);
  endfunction

  function automatic logic [31:0] exp_word(input int bank, input int w,
                                           input int npts);
    logic [15:0] lo, hi;
    int p0;
    p0 = 2 * (w - 2);
    lo = (p0 < npts) ? pval(bank, p0) : 16'h0;
    hi = (p0 + 1 < npts) ? pval(bank, p0 + 1) : 16'h0;
    return {hi, lo};
  endfunction

  task automatic idle_eng();
    addr_x = 0; addr_y = 0; addr_z = 0;
    write_in_x = 0; write_in_y = 0; write_in_z = 0;
    we_x = 0; we_y = 0; we_z = 0;
    en_x = 0; en_y = 0; en_z = 0;
    rst_x = 0; rst_y = 0; rst_z = 0;
  endtask

  task automatic set_eng(input int bank, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] we,
                         input logic clr);
    case (bank)
      0: begin
        addr_x = a; write_in_x = d; we_x = we; en_x = 1; rst_x = clr;
      end
      1: begin
        addr_y = a; write_in_y = d; we_y = we; en_y = 1; rst_y = clr;
      end
      default: begin
        addr_z = a; write_in_z = d; we_z = we; en_z = 1; rst_z = clr;
      end
    endcase
  endtask

  // Engine access: expectation queued at drive, checked at output.
  task automatic access(input string tag, input int dsel, input int bank,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] we, input logic clr,
                        input logic [31:0] exp);
    rd_t e;
    @(negedge clock);
    idle_eng();
    set_eng(bank, a, d, we, clr);
    rd_q.push_back('{dsel: dsel, bank: bank, exp: exp});
    tag_q.push_back(tag);
    @(negedge clock);
    idle_eng();
    e = rd_q.pop_front();
    check(tag_q.pop_front(), ro(e.dsel, e.bank), e.exp);
  endtask

  task automatic rd(input string tag, input int dsel, input int bank,
                    input logic [31:0] a, input logic [31:0] exp);
    access(tag, dsel, bank, a, 0, 4'h0, 1'b0, exp);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic last);
    int t;
    t = 0;
    @(negedge clock);
    while (!s_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("s_ready_timeout", 32'd0, 32'd1);
    s_valid = 1; s_x = x; s_y = y; s_z = z; s_last = last;
    @(negedge clock);
    s_valid = 0; s_last = 0;
  endtask

  task automatic ack();
    @(negedge clock);
    done_ack = 1;
    @(negedge clock);
    done_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 0; s_valid = 0; s_last = 0; done_ack = 0;
    s_x = 0; s_y = 0; s_z = 0;
    idle_eng();
    @(negedge clock);
    check("rst_s_ready", {31'b0, s_ready}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_overflow", {31'b0, overflow}, 0);
    check("rst_ro_x", ro_x, 0);
    reset_n = 1;
    @(negedge clock);
    check("ready_after_rst", {31'b0, s_ready}, 1);

    // Five-point cloud, then header ordering.
    for (int k = 0; k < 5; k++)
      send(pval(0, k), pval(1, k), pval(2, k), k == 4);
    check("hdr_busy", {31'b0, busy}, 1);
    check("hdr_ready", {31'b0, s_ready}, 0);
    en_x = 1; en_y = 1;
    @(negedge clock);
    @(negedge clock);
    check("hdr_size", ro_x, 5);
    check("flag_before_size", {31'b0, ro_y === 32'd1}, 0);
    @(negedge clock);
    check("hdr_flag", ro_y, 1);
    idle_eng();

    for (int b = 0; b < 3; b++)
      for (int w = 2; w < 5; w++)
        rd($sformatf("pt_b%0d_w%0d", b, w), 0, b, w << 2,
           exp_word(b, w, 5));
    rd("z_word0", 0, 2, 0, 0);
    access("rst_clear", 0, 0, 8, 0, 4'h0, 1'b1, 0);

    access("byte_wr_old", 0, 0, 8, 32'hAABBCCDD, 4'b0001, 0,
           32'h02020101);
    rd("byte_wr_new", 0, 0, 8, 32'h020201DD);
    rd("oor_read", 0, 0, 32'h1000, 0);
    access("oor_wr", 0, 0, 32'h1000, 32'h12345678, 4'hF, 0, 0);
    rd("x0_after_oor", 0, 0, 0, 5);

    access("y_clear", 0, 1, 0, 0, 4'hF, 0, 1);
    check("y_clear_done", {31'b0, done}, 0);
    check("run_busy", {31'b0, busy}, 1);
    access("done_wr", 0, 2, 0, 32'h0FFF, 4'hF, 0, 0);
    check("done_set", {31'b0, done}, 1);
    check("done_busy", {31'b0, busy}, 0);
    ack();
    check("ack_done", {31'b0, done}, 0);
    check("ack_ready", {31'b0, s_ready}, 1);

    // Engine write during load must be dropped.
    send(16'h1111, 16'h1111, 16'h1111, 0);
    check("load_busy", {31'b0, busy}, 1);
    access("ld_wr_ign", 0, 0, 8, 32'hDEADBEEF, 4'hF, 0, 32'h02021111);
    send(16'h2222, 16'h2222, 16'h2222, 1);
    @(negedge clock);
    @(negedge clock);
    rd("ld_intact", 0, 0, 8, 32'h22221111);
    rd("ld_count", 0, 0, 0, 2);
    access("done_wr2", 0, 2, 0, 32'h1, 4'h1, 0, 0);
    ack();

    // Reset in the middle of a load.
    rd("pre_rst", 0, 0, 8, 32'h22221111);
    for (int k = 0; k < 3; k++) send(16'h0A0A, 16'h0B0B, 16'h0C0C, 0);
    @(negedge clock);
    reset_n = 0;
    #1;
    check("mid_rst_ro_x", ro_x, 0);
    check("mid_rst_ready", {31'b0, s_ready}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    @(negedge clock);
    reset_n = 1;
    send(16'h0777, 16'h0888, 16'h0999, 1);
    @(negedge clock);
    @(negedge clock);
    rd("restart_count", 0, 0, 0, 1);
    rd("restart_x2", 0, 0, 8, 32'h00000777);
    rd("restart_y2", 0, 1, 8, 32'h00000888);
    access("done_wr3", 0, 2, 0, 32'h5, 4'hF, 0, 0);
    ack();

    // Overflow on the four-word copy.
    @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    check("ovf_ready_init", {31'b0, s_ready4}, 1);
    for (int i = 0; i < 6; i++) begin
      s_valid = 1; s_last = 0;
      s_x = pval(0, i); s_y = pval(1, i); s_z = pval(2, i);
      @(negedge clock);
      if (i == 3) begin
        check("ovf_ready", {31'b0, s_ready4}, 0);
        check("ovf_flag", {31'b0, overflow4}, 1);
      end
    end
    s_valid = 0;
    rd("ovf_count", 1, 0, 0, 4);
    rd("ovf_w3", 1, 0, 12, exp_word(0, 3, 4));
    check("ovf_sticky", {31'b0, overflow4}, 1);
    access("ovf_done_wr", 1, 2, 0, 32'h1, 4'hF, 0, 0);
    check("ovf_done", {31'b0, done4}, 1);
    ack();
    check("ovf_cleared", {31'b0, overflow4}, 0);
    check("ovf_ack_done", {31'b0, done4}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/point_cloud_bram_responder.md
POINT_CLOUD_BRAM_RESPONDER -- requirements
Module: point_cloud_bram_responder

Interface
REQ-001 Parameter N, default 16, coordinate width in bits.
REQ-002 Parameter BUS_SIZE, default 32, BRAM word width; points per word PPW = BUS_SIZE/N = 2.
REQ-003 Parameter BRAM_SHIFT, default 2, byte-to-word address shift.
REQ-004 Parameter DEPTH, default 1024, words per axis bank; MAX_POINTS = (DEPTH-2)*PPW.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 addr_{x,y,z}  in  32 each  engine byte address; word = addr>>BRAM_SHIFT.
REQ-008 write_in_{x,y,z}  in  BUS_SIZE each  engine write data.
REQ-009 we_{x,y,z}  in  4 each  engine byte write enables.
REQ-010 en_{x,y,z}  in  1 each  engine port enable.
REQ-011 rst_{x,y,z}  in  1 each  synchronous read-register clear.
REQ-012 read_out_{x,y,z}  out  BUS_SIZE each  registered read data.
REQ-013 s_valid, s_ready  in/out  1  host point-stream handshake.
REQ-014 s_x, s_y, s_z  in  N each  host point coordinates; s_last  in  1  final point.
REQ-015 done  out  1  engine finished; done_ack  in  1  host release.
REQ-016 busy  out  1  load or run active; overflow  out  1  stream exceeded MAX_POINTS.

Function
REQ-017 Engine port SHALL read with 1-cycle latency: en=1 at edge k -> read_out = word(addr) after edge k; en=0 holds read_out.
REQ-018 en=1 and rst=1 SHALL load read_out with 0 instead of memory data.
REQ-019 Engine writes SHALL apply per-byte per we bit, read-first (read_out returns old word), only in state RUN; dropped otherwise.
REQ-020 Out-of-range word (>= DEPTH) SHALL read 0 and drop writes.
REQ-021 FSM states: IDLE, LOAD, HDR_SIZE, HDR_GO, RUN, DONE.
REQ-022 IDLE: s_ready=1; first accepted beat -> LOAD (beat stored as point 0); s_last on that beat -> HDR_SIZE.
REQ-023 LOAD: s_ready=1 while count < MAX_POINTS; s_last accepted -> HDR_SIZE.
REQ-024 Point k SHALL go to word 2+k/PPW of each bank; even k low half (we=0011), odd k high half (we=1100).
REQ-025 Final point with even k SHALL write full word, high half zero.
REQ-026 Count reaching MAX_POINTS without s_last: s_ready=0, overflow=1 (sticky until IDLE), -> HDR_SIZE with count MAX_POINTS.
REQ-027 HDR_SIZE (1 cycle): x word0 = count, z word0 = 0 -> HDR_GO.
REQ-028 HDR_GO (1 cycle): y word0 = 1 (start flag) -> RUN; size always visible before flag.
REQ-029 RUN: engine write to z word0 with any we bit set and nonzero data -> DONE; engine clearing y word0 is legal, no transition.
REQ-030 DONE: done=1; done_ack -> IDLE, done=0, overflow=0.
REQ-031 busy=1 in all states except IDLE and DONE.
REQ-032 Loader write and engine write to same word same cycle impossible (engine writes gated to RUN); engine reads during load return current contents.
REQ-033 Point counter width SHALL be 32 bits; x word0 holds it zero-extended.

Reset
REQ-034 reset_n low SHALL immediately force IDLE, counter 0, read_out_* 0, s_ready 0, done 0, busy 0, overflow 0; s_ready rises first edge after release.
REQ-035 Memory contents SHALL NOT be cleared by reset; mid-load reset abandons the partial cloud, header untouched.

Structure
REQ-036 Shared package: N, BUS_SIZE, BRAM_SHIFT, PPW, HEADER_WORDS=2, FSM state encoding.
REQ-037 One sub-module pc_bram_bank (single-port, byte-enable, read-first, registered output, loader/engine write mux), instantiated for x, y, z.

Verification
REQ-038 Stream 5 points (x=0x0101..0x0505), last on 5th -> x word2=0x02020101, word4=0x00000505, x word0=5 one cycle before y word0=1.
REQ-039 RUN, engine read addr 0x8 en=1 -> next cycle read_out_x=0x02020101; rst_x=1 same -> 0.
REQ-040 RUN, engine writes z addr 0 data 0x0FFF we=F -> done=1 next cycle; done_ack -> IDLE, done=0.
REQ-041 DEPTH=4, stream 6 points no s_last -> s_ready=0 after 4, overflow=1, x word0=4.
REQ-042 reset_n low mid-LOAD after 3 beats -> outputs zero at once; restart with 1 point -> x word0=1.
REQ-043 Engine write during LOAD to word 2 -> ignored; loader data intact.
